// File: rtl/dcache_read_responder.sv
// dcache_read_responder
// Read-only, direct-mapped data cache with 8-byte lines that answers the
// memory stage's read requests. Misses are filled from main memory over a
// req/ready handshake. Valid bits, tags and data are all held in flops.

module dcache_read_responder #(
  parameter int INDEX_BITS = 5,
  parameter int TAG_BITS   = 29 - INDEX_BITS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dcache_en,
  input  logic [31:0] address,
  input  logic        invalidate,
  output logic [63:0] dcache_data,
  output logic        dcache_ready,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [63:0] mem_data,
  input  logic        mem_ready
);

  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_t;

  state_t                state_q;
  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [63:0]           data_q [LINES];
  logic [63:0]           resp_data_q;
  logic [31:0]           mem_addr_q;
  logic                  mem_req_q;
  logic                  ready_q;
  logic                  inval_seen_q;

  logic [INDEX_BITS-1:0] req_index;
  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] fill_index;
  logic [TAG_BITS-1:0]   fill_tag;
  logic                  hit;
  logic                  fill_write;
  logic                  unused_addr_bits;

  assign req_index  = address[3+INDEX_BITS-1:3];
  assign req_tag    = address[31:3+INDEX_BITS];
  assign fill_index = mem_addr_q[3+INDEX_BITS-1:3];
  assign fill_tag   = mem_addr_q[31:3+INDEX_BITS];
  assign fill_write = (state_q == FILL) && mem_ready && !reset;

  // Byte offset within the quadword is resolved by the memory stage.
  assign unused_addr_bits = ^address[2:0];

  // Lookup of the requested line; only meaningful while IDLE.
  always_comb begin
    hit = valid_q[req_index] && (tag_q[req_index] == req_tag);
  end

  // Tag and data arrays are written only by a completing fill; they carry no
  // reset because the valid bits alone decide whether a line is usable.
  always_ff @(posedge clk) begin
    if (fill_write) begin
      tag_q[fill_index]  <= fill_tag;
      data_q[fill_index] <= mem_data;
    end
  end

  // Request FSM with registered outputs, plus valid-bit maintenance. An
  // invalidate seen at any point during a fill poisons that fill so the line
  // it installs stays invalid, while the data is still handed back.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      resp_data_q  <= '0;
      mem_addr_q   <= '0;
      mem_req_q    <= 1'b0;
      ready_q      <= 1'b0;
      inval_seen_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;

      if (invalidate) begin
        valid_q <= '0;
      end else if (fill_write && !inval_seen_q) begin
        valid_q[fill_index] <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          inval_seen_q <= 1'b0;
          if (dcache_en) begin
            if (hit) begin
              resp_data_q <= data_q[req_index];
              ready_q     <= 1'b1;
              state_q     <= DONE;
            end else begin
              mem_addr_q <= {address[31:3], 3'b000};
              mem_req_q  <= 1'b1;
              state_q    <= FILL;
            end
          end
        end
        FILL: begin
          if (invalidate) begin
            inval_seen_q <= 1'b1;
          end
          if (mem_ready) begin
            resp_data_q <= mem_data;
            mem_req_q   <= 1'b0;
            ready_q     <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dcache_data  = resp_data_q;
  assign dcache_ready = ready_q;
  assign mem_req      = mem_req_q;
  assign mem_addr     = mem_addr_q;

endmodule

// File: tb/tb_dcache_read_responder.sv
// tb_dcache_read_responder
// Drives directed and random read requests into dcache_read_responder. A
// line-level cache model (which line address each index holds and whether it
// is valid) plus a lazily populated memory image predict, cycle by cycle,
// whether mem_req and dcache_ready must be high and what data must appear.

module tb_dcache_read_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        dcache_en;
  logic [31:0] address;
  logic        invalidate;
  logic [63:0] dcache_data;
  logic        dcache_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [63:0] mem_data;
  logic        mem_ready;

  dcache_read_responder #(.INDEX_BITS(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .dcache_en    (dcache_en),
    .address      (address),
    .invalidate   (invalidate),
    .dcache_data  (dcache_data),
    .dcache_ready (dcache_ready),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_ready    (mem_ready)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  int nCompared = 0;
  int nMismatched = 0;
  int cyc = 0;

  // Cycle counter used to measure latencies and pulse spacing.
  always @(posedge clk) cyc++;

  bit          checkOn = 1'b0;
  logic        expReady = 1'b0;
  logic        expReq = 1'b0;
  logic [31:0] expAddr = '0;
  logic [63:0] expData = '0;

  logic [63:0] lastData = '0;
  logic [31:0] lastReqAddr = '0;
  int          lastReadyCyc = 0;
  int          reqCycles = 0;
  int          startCyc = 0;

  bit          mValid [32];
  logic [31:0] mLine  [32];
  logic [63:0] memImg [logic [31:0]];

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] memWord(input logic [31:0] line);
    if (!memImg.exists(line)) memImg[line] = {$urandom, $urandom};
    return memImg[line];
  endfunction

  function automatic void modelClear();
    for (int i = 0; i < 32; i++) mValid[i] = 1'b0;
  endfunction

  task automatic checkOutput();
    cmp("dcache_ready", {63'd0, dcache_ready}, {63'd0, expReady});
    cmp("mem_req", {63'd0, mem_req}, {63'd0, expReq});
    if (expReq) cmp("mem_addr", {32'd0, mem_addr}, {32'd0, expAddr});
    if (expReady) cmp("dcache_data", dcache_data, expData);
    if (mem_req === 1'b1) begin
      reqCycles++;
      lastReqAddr = mem_addr;
    end
    if (dcache_ready === 1'b1) begin
      lastData = dcache_data;
      lastReadyCyc = cyc;
    end
  endtask

  // Single compare process: outputs sampled mid-cycle on the falling edge.
  always @(negedge clk) if (checkOn) checkOutput();

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One read request from IDLE through DONE. lat = FILL cycles before and
  // including the mem_ready cycle; invCycle = FILL cycle to pulse invalidate
  // (0 = none); dropEn drops dcache_en during the fill; keepEn leaves
  // dcache_en high after DONE so the next request follows immediately.
  task automatic applyStimulus(input logic [31:0] addr, input int lat, input int invCycle,
                               input bit dropEn, input bit keepEn);
    logic [31:0] line;
    int          idx;
    bit          isHit;
    bit          poisoned;
    line     = {addr[31:3], 3'b000};
    idx      = int'(addr[7:3]);
    isHit    = mValid[idx] && (mLine[idx] == line);
    poisoned = 1'b0;
    reqCycles = 0;
    startCyc  = cyc;
    dcache_en = 1'b1;
    address   = addr;
    expReady  = 1'b0;
    expReq    = 1'b0;
    step();
    if (!isHit) begin
      for (int c = 1; c <= lat; c++) begin
        expReq  = 1'b1;
        expAddr = line;
        if (c == invCycle) begin
          invalidate = 1'b1;
          poisoned = 1'b1;
          modelClear();
        end
        if (dropEn && c == 1) dcache_en = 1'b0;
        if (c == lat) begin
          mem_ready = 1'b1;
          mem_data  = memWord(line);
        end
        step();
        invalidate = 1'b0;
        mem_ready  = 1'b0;
        mem_data   = {$urandom, $urandom};
      end
      mLine[idx]  = line;
      mValid[idx] = !poisoned;
    end
    expReq   = 1'b0;
    expReady = 1'b1;
    expData  = memWord(line);
    if (!keepEn) dcache_en = 1'b0;
    step();
    expReady = 1'b0;
  endtask

  task automatic idleCycle(input bit inv);
    dcache_en  = 1'b0;
    invalidate = inv;
    expReady   = 1'b0;
    expReq     = 1'b0;
    if (inv) modelClear();
    step();
    invalidate = 1'b0;
  endtask

  // Reset while a fill is outstanding, then a stray mem_ready two cycles on.
  task automatic resetMidFill(input logic [31:0] addr);
    dcache_en = 1'b1;
    address   = addr;
    expReady  = 1'b0;
    expReq    = 1'b0;
    step();
    expReq  = 1'b1;
    expAddr = {addr[31:3], 3'b000};
    reset   = 1'b1;
    step();
    reset     = 1'b0;
    dcache_en = 1'b0;
    expReq    = 1'b0;
    modelClear();
    cmp("reset_mem_addr", {32'd0, mem_addr}, 64'd0);
    step();
    mem_ready = 1'b1;
    mem_data  = {$urandom, $urandom};
    step();
    mem_ready = 1'b0;
    step();
    step();
  endtask

  // Watchdog so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int firstReady;
    logic [31:0] a;
    reset      = 1'b1;
    dcache_en  = 1'b0;
    address    = '0;
    invalidate = 1'b0;
    mem_data   = '0;
    mem_ready  = 1'b0;
    modelClear();
    for (int i = 0; i < 32; i++) mLine[i] = '0;
    memImg[32'h0000_1000] = 64'h1122_3344_5566_7788;
    step();
    step();
    checkOn = 1'b1;
    step();
    cmp("reset_dcache_data", dcache_data, 64'd0);
    cmp("reset_mem_addr", {32'd0, mem_addr}, 64'd0);
    reset = 1'b0;
    step();

    // Cold miss: mem_ready three cycles after mem_req first rises.
    applyStimulus(32'h0000_1004, 4, 0, 1'b0, 1'b0);
    cmp("cold_data", lastData, 64'h1122_3344_5566_7788);
    cmp("cold_fill_addr", {32'd0, lastReqAddr}, 64'h0000_1000);
    cmp("cold_latency", 64'(lastReadyCyc - startCyc), 64'd5);
    idleCycle(1'b0);

    // Hit after fill: no mem_req, ready one cycle after en sampled.
    applyStimulus(32'h0000_1000, 2, 0, 1'b0, 1'b0);
    cmp("hit_req_cycles", 64'(reqCycles), 64'd0);
    cmp("hit_latency", 64'(lastReadyCyc - startCyc), 64'd1);
    cmp("hit_data", lastData, 64'h1122_3344_5566_7788);

    // Conflict: same index, different tag evicts; the old line misses again.
    applyStimulus(32'h0000_1100, 2, 0, 1'b0, 1'b0);
    cmp("conflict_req_cycles", 64'(reqCycles), 64'd2);
    cmp("conflict_fill_addr", {32'd0, lastReqAddr}, 64'h0000_1100);
    applyStimulus(32'h0000_1000, 3, 0, 1'b0, 1'b0);
    cmp("reread_req_cycles", 64'(reqCycles), 64'd3);
    cmp("reread_data", lastData, 64'h1122_3344_5566_7788);

    // Invalidate during fill: data returned, line left invalid.
    applyStimulus(32'h0000_2008, 3, 2, 1'b0, 1'b0);
    applyStimulus(32'h0000_2008, 1, 0, 1'b0, 1'b0);
    cmp("post_inval_req_cycles", 64'(reqCycles), 64'd1);
    // Invalidate coinciding with mem_ready also leaves the line invalid.
    applyStimulus(32'h0000_2010, 2, 2, 1'b0, 1'b0);
    applyStimulus(32'h0000_2010, 1, 0, 1'b0, 1'b0);
    cmp("coincident_inval_req_cycles", 64'(reqCycles), 64'd1);

    // Reset mid-fill, stray mem_ready ignored, next request misses.
    resetMidFill(32'h0000_3010);
    applyStimulus(32'h0000_3010, 2, 0, 1'b0, 1'b0);
    cmp("post_reset_req_cycles", 64'(reqCycles), 64'd2);

    // Back-to-back hits with dcache_en held high across two addresses.
    applyStimulus(32'h0000_4000, 1, 0, 1'b0, 1'b0);
    applyStimulus(32'h0000_4008, 1, 0, 1'b0, 1'b0);
    applyStimulus(32'h0000_4000, 1, 0, 1'b0, 1'b1);
    firstReady = lastReadyCyc;
    applyStimulus(32'h0000_4008, 1, 0, 1'b0, 1'b0);
    cmp("b2b_spacing", 64'(lastReadyCyc - firstReady), 64'd2);

    // Fill still completes when dcache_en drops mid-fill; line then hits.
    applyStimulus(32'h0000_5018, 3, 0, 1'b1, 1'b0);
    applyStimulus(32'h0000_5018, 1, 0, 1'b0, 1'b0);
    cmp("dropped_en_hit_req_cycles", 64'(reqCycles), 64'd0);

    // Randomized traffic over a small address pool to mix hits and conflicts.
    for (int n = 0; n < 300; n++) begin
      int lat;
      int inv;
      a = 32'h0006_0000 + (32'($urandom_range(0, 3)) << 8)
        + (32'($urandom_range(0, 7)) << 3) + 32'($urandom_range(0, 7));
      lat = $urandom_range(1, 4);
      inv = ($urandom_range(0, 7) == 0) ? $urandom_range(1, lat) : 0;
      applyStimulus(a, lat, inv, $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0);
      case ($urandom_range(0, 9))
        0: idleCycle(1'b1);
        1, 2: idleCycle(1'b0);
        default: ;
      endcase
    end
    idleCycle(1'b0);
    checkOn = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
